// File: rtl/keypad_pkg.sv
// Purpose: shared types and key decode for the 4x4 matrix keypad scanner.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
// Contents: KEY_NONE blank code, scanner FSM state encoding, map_key(row, col) decode.
package keypad_pkg;

  // Blank/none code understood by the downstream digit-entry memory.
  localparam logic [4:0] KEY_NONE = 5'd16;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESS,
    ST_HELD,
    ST_RELEASE
  } state_t;

  // Layout:  r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
  // A-D -> 10-13, * -> 14, # -> 15.
  function automatic logic [4:0] map_key(input logic [1:0] row, input logic [1:0] col);
    logic [4:0] code;
    case ({row, col})
      4'h0:    code = 5'd1;
      4'h1:    code = 5'd2;
      4'h2:    code = 5'd3;
      4'h3:    code = 5'd10;
      4'h4:    code = 5'd4;
      4'h5:    code = 5'd5;
      4'h6:    code = 5'd6;
      4'h7:    code = 5'd11;
      4'h8:    code = 5'd7;
      4'h9:    code = 5'd8;
      4'hA:    code = 5'd9;
      4'hB:    code = 5'd12;
      4'hC:    code = 5'd14;
      4'hD:    code = 5'd0;
      4'hE:    code = 5'd15;
      default: code = 5'd13;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchroniser for asynchronous keypad row lines.
// Latency: 2 clk from d to q.
// Backpressure: none; free-running.
// Ports: clk, reset (async active-low, flops reset to all ones = no row pulled low),
//        d (async input), q (synchronised output).
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: scan a 4x4 active-low keypad, debounce, emit a 5-bit key code plus one-clk press strobe.
// Latency: key_valid 2 + <=4*SCAN_DIV + DEBOUNCE_CYC + 1 clk after a clean press edge.
// Backpressure: none; key_code is held until the next press so the consumer may sample late.
// Ports: clk; reset (async active-low); row_n[3:0] async rows; col_n[3:0] one-cold column drive;
//        key_code[4:0] (0-15 key, 16 none); key_valid press/repeat strobe; key_held debounced key down.
// Build option: define KEYPAD_REPEAT_EN to add held-key auto-repeat (REPEAT_DLY / REPEAT_PER).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 500000
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_PER   = 10000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // One counter serves both the per-column dwell and the press/release debounce.
  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [4:0]       code_q, code_d;
  logic [3:0]       rs;
  logic [1:0]       hit_row;
  logic             row_low;
  logic             rep_fire;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (rs)
  );

  // Lowest-index low row wins within the driven column.
  always_comb begin
    hit_row = 2'd3;
    if (!rs[2]) hit_row = 2'd2;
    if (!rs[1]) hit_row = 2'd1;
    if (!rs[0]) hit_row = 2'd0;
  end

  // Latched row of the key being tracked; column stays frozen while tracking.
  assign row_low = ~rs[row_q];

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_phase_q;  // 0: waiting initial delay, 1: periodic repeats
  logic [REP_W-1:0] rep_lim;

  assign rep_lim  = rep_phase_q ? REP_W'(REPEAT_PER - 1) : REP_W'(REPEAT_DLY - 1);
  assign rep_fire = (state_q == ST_HELD) && (rep_cnt_q == rep_lim);

  // HELD is entered one clk after the press strobe, so the first repeat lands
  // REPEAT_DLY clks after that strobe. Any exit from HELD restarts the timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else if (state_q != ST_HELD) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_q + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SCAN;
      cnt_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      code_q  <= KEY_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    code_d    = code_q;
    key_valid = 1'b0;
    key_held  = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (rs != 4'hF) begin
            row_d   = hit_row;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!row_low) begin
          // Bounce: rescan the same column from scratch.
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else if (cnt_q == DEB_LAST) begin
          // Load the code here so it is already valid while the strobe is high.
          cnt_d   = '0;
          code_d  = map_key(row_q, col_q);
          state_d = ST_PRESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESS: begin
        key_valid = 1'b1;
        state_d   = ST_HELD;
      end
      ST_HELD: begin
        key_held = 1'b1;
        if (!row_low) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          key_valid = rep_fire;
        end
      end
      ST_RELEASE: begin
        key_held = 1'b1;
        if (row_low) begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SCAN;
      end
    endcase
  end

  assign col_n    = ~(4'b0001 << col_q);
  assign key_code = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: directed self-checking bench for keypad_scanner with a behavioural 4x4 keypad.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;  // bit r*4+c = key at row r, column c is down

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  int n_strobe = 0;
  int consec_err = 0;
  logic prev_valid = 1'b0;
  int         stb_cyc  [32];
  logic [4:0] stb_code [32];

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DLY   (40),
    .REPEAT_PER   (16)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive keypad: a down key shorts its row to its column when that column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Strobe recorder.
  always @(negedge clk) begin
    if (key_valid) begin
      if (prev_valid) consec_err++;
      if (n_strobe < 32) begin
        stb_cyc[n_strobe]  = cyc;
        stb_code[n_strobe] = key_code;
      end
      n_strobe++;
    end
    prev_valid = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_strobe(input int base, input int limit, input string tag);
    int i = 0;
    while (n_strobe == base && i < limit) begin
      step(1);
      i++;
    end
    check(tag, (n_strobe > base) ? 1 : 0, 1);
  endtask

  task automatic wait_released(input int limit, input string tag);
    int i = 0;
    while (key_held !== 1'b0 && i < limit) begin
      step(1);
      i++;
    end
    check(tag, key_held, 0);
  endtask

  // Returns just after col_n switches to target (dwell counter at 0).
  task automatic wait_col(input logic [3:0] target, input string tag);
    int i = 0;
    while (col_n == target && i < 40) begin
      step(1);
      i++;
    end
    while (col_n != target && i < 80) begin
      step(1);
      i++;
    end
    check(tag, col_n, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},   col_n,     4'b1110);
    check({tag, "_code"},  key_code,  5'd16);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_held"},  key_held,  0);
  endtask

  initial begin
    int base;
    int p;
    logic [3:0] exp_col;

    keys  = '0;
    reset = 1'b0;

    // 1: reset values, idle column rotation
    step(3);
    check_reset_outputs("t1_rst");
    reset = 1'b1;
    for (int j = 0; j < 20; j++) begin
      exp_col = ~(4'b0001 << ((j / 4) % 4));
      check("t1_col_rot", col_n, exp_col);
      step(1);
    end
    check("t1_code_idle", key_code, 16);
    check("t1_no_strobe", n_strobe, 0);

    // 2: clean press of '7' (r2,c0)
    base = n_strobe;
    keys[8] = 1'b1;
    wait_strobe(base, 60, "t2_strobe");
    check("t2_stb_code", stb_code[base], 7);
    step(20);
    check("t2_one_strobe", n_strobe - base, 1);
    check("t2_code", key_code, 7);
    check("t2_held", key_held, 1);
    keys = '0;
    step(2);
    check("t2_held_during_rel", key_held, 1);
    step(12);
    check("t2_released", key_held, 0);
    check("t2_code_kept", key_code, 7);
    check("t2_still_one", n_strobe - base, 1);

    // 3: 'D' (r3,c3) with 3-clk bounces
    base = n_strobe;
    wait_col(4'b0111, "t3_col3");
    repeat (4) begin
      keys[15] = 1'b1;
      step(3);
      keys[15] = 1'b0;
      step(3);
    end
    check("t3_no_bounce_strobe", n_strobe - base, 0);
    keys[15] = 1'b1;
    wait_strobe(base, 60, "t3_strobe");
    check("t3_stb_code", stb_code[base], 13);
    step(20);
    check("t3_one_strobe", n_strobe - base, 1);
    keys = '0;
    wait_released(40, "t3_released");

    // 4: '5' (r1,c1) held, then '9' (r2,c2) added
    base = n_strobe;
    keys[5] = 1'b1;
    wait_strobe(base, 60, "t4_strobe5");
    check("t4_stb_code5", stb_code[base], 5);
    step(3);
    keys[10] = 1'b1;
    step(40);
    check("t4_only5", n_strobe - base, 1);
    check("t4_code5", key_code, 5);
    keys = '0;
    wait_released(40, "t4_rel_both");
    base = n_strobe;
    keys[10] = 1'b1;
    wait_strobe(base, 60, "t4_strobe9");
    check("t4_stb_code9", stb_code[base], 9);
    keys = '0;
    wait_released(40, "t4_rel9");

    // 5a: reset mid-DEBOUNCE on '2' (r0,c1)
    base = n_strobe;
    wait_col(4'b1101, "t5_col1");
    keys[1] = 1'b1;
    step(8);
    check("t5a_no_early_strobe", n_strobe - base, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("t5a_rst");
    keys = '0;
    step(2);
    reset = 1'b1;
    step(40);
    check("t5a_no_strobe", n_strobe - base, 0);

    // 5b: reset mid-HELD on '6' (r1,c2)
    base = n_strobe;
    keys[6] = 1'b1;
    wait_strobe(base, 60, "t5b_strobe");
    step(5);
    check("t5b_held", key_held, 1);
    check("t5b_code", key_code, 6);
    reset = 1'b0;
    #1;
    check_reset_outputs("t5b_rst");
    keys = '0;
    step(2);
    reset = 1'b1;
    step(40);
    check("t5b_no_strobe", n_strobe - base, 1);

    // 6: hold '#' (r3,c2) for 100 clks
    base = n_strobe;
    keys[14] = 1'b1;
    wait_strobe(base, 60, "t6_strobe");
    p = stb_cyc[base];
    step(100);
    keys = '0;
`ifdef KEYPAD_REPEAT_EN
    check("t6_count", n_strobe - base, 5);
    check("t6_rep1", stb_cyc[base+1] - p, 40);
    check("t6_rep2", stb_cyc[base+2] - p, 56);
    check("t6_rep3", stb_cyc[base+3] - p, 72);
    check("t6_rep4", stb_cyc[base+4] - p, 88);
    for (int i = 0; i < 5; i++) check("t6_code", stb_code[base+i], 15);
`else
    check("t6_count", n_strobe - base, 1);
    check("t6_code", stb_code[base], 15);
`endif
    wait_released(40, "t6_released");
    check("no_back_to_back", consec_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
